// File: rtl/detect_event_display_pkg.sv
// Shared constants for the detect-event display slice.
// Holds the active-low segment patterns {dp,g,f,e,d,c,b,a} and the digit
// enable codes; dp is always off (1) in every pattern.
package detect_event_display_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // an is active-low: bit 0 enables units, bit 1 enables tens.
   localparam logic [1:0] AN_UNITS  = 2'b10;
   localparam logic [1:0] AN_TENS   = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern decoder.
// Ports: bcd (4-bit digit in), seg (8-bit {dp,g,f,e,d,c,b,a} out, active-low).
// Non-BCD codes blank the digit.
module bcd_to_seg7
   import detect_event_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/detect_event_display.sv
// Counts rising edges of 'detect' as a 2-digit BCD tally with sticky wrap flag,
// and scans the tally onto a 2-digit multiplexed active-low 7-segment display.
// Ports: clk/rst (async active-low), detect, clr -> count_bcd, ovf, an, seg.
module detect_event_display
   import detect_event_display_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int CNT_MAX  = 99
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       detect,
   input  logic       clr,
   output logic [7:0] count_bcd,
   output logic       ovf,
   output logic [1:0] an,
   output logic [7:0] seg
);

   localparam int         SCW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [7:0] CNT_MAX_BCD = {4'(CNT_MAX / 10), 4'(CNT_MAX % 10)};

   logic           r_det_d;
   logic [7:0]     r_count;
   logic           r_ovf;
   logic [SCW-1:0] r_scan_cnt;
   logic [1:0]     r_an;
   logic [7:0]     r_seg;

   logic           w_inc;
   logic           w_wrap;
   logic [7:0]     w_cnt_nxt;
   logic           w_scan_last;
   logic [1:0]     w_an_nxt;
   logic [3:0]     w_digit_nxt;
   logic [7:0]     w_seg_nxt;

   assign w_inc  = detect & ~r_det_d;
   assign w_wrap = w_inc && (r_count == CNT_MAX_BCD);

   // Next count: clear wins over increment.
   always_comb begin
      w_cnt_nxt = r_count;
      if (clr) begin
         w_cnt_nxt = 8'h00;
      end else if (w_inc) begin
         if (r_count == CNT_MAX_BCD) begin
            w_cnt_nxt = 8'h00;
         end else if (r_count[3:0] == 4'd9) begin
            w_cnt_nxt = {r_count[7:4] + 4'd1, 4'd0};
         end else begin
            w_cnt_nxt = {r_count[7:4], r_count[3:0] + 4'd1};
         end
      end
   end

   assign w_scan_last = (r_scan_cnt == SCAN_LAST);
   assign w_an_nxt    = w_scan_last ? ~r_an : r_an;

   // Segments are decoded from the post-update count and post-update select,
   // so the pattern lands on the same edge as the count/digit change.
   assign w_digit_nxt = (w_an_nxt == AN_UNITS) ? w_cnt_nxt[3:0] : w_cnt_nxt[7:4];

   bcd_to_seg7 u_dec (
      .bcd (w_digit_nxt),
      .seg (w_seg_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_det_d    <= 1'b0;
         r_count    <= 8'h00;
         r_ovf      <= 1'b0;
         r_scan_cnt <= '0;
         r_an       <= AN_UNITS;
         r_seg      <= SEG_0;
      end else begin
         // det_d tracks detect even during clr so a held level is not recounted.
         r_det_d    <= detect;
         r_count    <= w_cnt_nxt;
         if (clr) begin
            r_ovf <= 1'b0;
         end else if (w_wrap) begin
            r_ovf <= 1'b1;
         end
         r_scan_cnt <= w_scan_last ? '0 : r_scan_cnt + 1'b1;
         r_an       <= w_an_nxt;
         r_seg      <= w_seg_nxt;
      end
   end

   assign count_bcd = r_count;
   assign ovf       = r_ovf;
   assign an        = r_an;
   assign seg       = r_seg;

endmodule

// File: tb/tb_detect_event_display.sv
// Directed bench for detect_event_display with SCAN_DIV=4, 10 ns clock.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_detect_event_display;

   logic       clk;
   logic       rst;
   logic       detect;
   logic       clr;
   logic [7:0] count_bcd;
   logic       ovf;
   logic [1:0] an;
   logic [7:0] seg;

   int n_chk = 0;
   int n_bad = 0;

   detect_event_display #(.SCAN_DIV(4), .CNT_MAX(99)) dut (
      .clk       (clk),
      .rst       (rst),
      .detect    (detect),
      .clr       (clr),
      .count_bcd (count_bcd),
      .ovf       (ovf),
      .an        (an),
      .seg       (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      detect = 1'b1;
      tick();
      detect = 1'b0;
      tick();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) pulse();
   endtask

   // Expected segment pattern for the digit currently enabled by an.
   function automatic logic [7:0] exp_seg(input logic [1:0] a, input logic [7:0] c);
      logic [7:0] tbl [10];
      logic [3:0] d;
      tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      d = (a == 2'b10) ? c[3:0] : c[7:4];
      return tbl[d];
   endfunction

   initial begin
      int run;
      int guard;
      logic [1:0] prev_an;

      rst    = 1'b0;
      detect = 1'b0;
      clr    = 1'b0;

      // 1: reset state and scan cadence
      #20;
      chk("rst_count", count_bcd, 8'h00);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_an", an, 2'b10);
      chk("rst_seg", seg, 8'hC0);
      @(negedge clk);
      rst = 1'b1;
      tick(); tick(); tick();
      chk("scan_hold3", an, 2'b10);
      tick();
      chk("scan_tog1", an, 2'b01);
      chk("scan_seg_tens0", seg, 8'hC0);
      tick(); tick(); tick();
      chk("scan_hold_t", an, 2'b01);
      tick();
      chk("scan_tog2", an, 2'b10);

      // 2: single, held and back-to-back pulses
      detect = 1'b1;
      tick();
      chk("single_imm", count_bcd, 8'h01);
      detect = 1'b0;
      tick();
      chk("single", count_bcd, 8'h01);
      detect = 1'b1;
      repeat (7) tick();
      detect = 1'b0;
      tick();
      chk("held7", count_bcd, 8'h02);
      detect = 1'b1; tick();
      detect = 1'b0; tick();
      detect = 1'b1; tick();
      detect = 1'b0; tick();
      chk("b2b_1010", count_bcd, 8'h04);

      // 3: carry and wrap
      do_clr();
      chk("clr", count_bcd, 8'h00);
      pulses(9);
      chk("to09", count_bcd, 8'h09);
      pulse();
      chk("carry10", count_bcd, 8'h10);
      do_clr();
      pulses(99);
      chk("to99", count_bcd, 8'h99);
      chk("ovf_99", ovf, 1'b0);
      pulse();
      chk("wrap00", count_bcd, 8'h00);
      chk("ovf_wrap", ovf, 1'b1);
      pulse();
      chk("after_wrap", count_bcd, 8'h01);
      chk("ovf_sticky", ovf, 1'b1);

      // 4: clear beats increment; held detect across release not recounted
      detect = 1'b1;
      clr    = 1'b1;
      tick();
      chk("clrpri_cnt", count_bcd, 8'h00);
      chk("clrpri_ovf", ovf, 1'b0);
      clr = 1'b0;
      tick(); tick();
      chk("held_over_clr", count_bcd, 8'h00);
      detect = 1'b0;
      tick();

      // 5: display of 37, each digit held exactly 4 clocks
      pulses(37);
      chk("to37", count_bcd, 8'h37);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("disp37", seg, (an == 2'b10) ? 8'hF8 : 8'hB0);
         chk("disp37_onehot", an ^ 2'b11, (an == 2'b10) ? 2'b01 : 2'b10);
      end
      // align to a digit change, then measure three runs
      prev_an = an;
      guard = 0;
      while (an == prev_an && guard < 8) begin
         tick();
         guard++;
      end
      chk("disp_align", (guard < 8) ? 1 : 0, 1);
      for (int r = 0; r < 3; r++) begin
         prev_an = an;
         run = 0;
         while (an == prev_an && run < 10) begin
            chk("disp_seg_run", seg, exp_seg(an, 8'h37));
            tick();
            run++;
         end
         chk("disp_hold4", run, 4);
      end

      // 6: async reset mid-count, detect high at release counts once
      do_clr();
      pulses(42);
      chk("to42", count_bcd, 8'h42);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_count", count_bcd, 8'h00);
      chk("arst_an", an, 2'b10);
      chk("arst_seg", seg, 8'hC0);
      chk("arst_ovf", ovf, 1'b0);
      detect = 1'b1;
      #1;
      rst = 1'b1;
      tick();
      chk("rel_first", count_bcd, 8'h01);
      chk("rel_seg", seg, 8'hF9);
      tick();
      chk("rel_held", count_bcd, 8'h01);
      detect = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
